// File: rtl/eigenportfolio_n.sv
// ---------------------------------------------------------------------------
// eigenportfolio_n
//
// Picks the eigenvector whose eigenvalue has a run-time rank (0 = largest,
// ties go to the lower column index). It then normalises that vector into
// fixed-point portfolio weights Q(WIDTH-FRAC).FRAC, using one shared
// sequential restoring divider.
//
// Flow: IDLE -> RANK (N cycles) -> SUM (N cycles)
//       -> DIV (N*(WIDTH+FRAC+1) cycles) -> DONE_ST -> IDLE
// The rank-error and zero-sum paths jump straight to DONE_ST.
//
// Optional build macro:
//   ABS_NORM_EN  When defined, the divisor is sum(|v_i|) (gross-leverage
//                normalisation). When undefined, the divisor is sum(v_i).
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   start         request pulse, only honoured in IDLE
//   rank          eigenvalue rank to select (0 = largest)
//   eigenvectors  [r][c] element, column c is eigenvector c
//   eigenvalues   [c] eigenvalue paired with column c
//   busy          high from request acceptance until done
//   done          one-cycle result-valid pulse
//   err           rank out of range or zero divisor (held until next start)
//   sat           at least one weight clamped (held until next start)
//   sel_idx       selected column index
//   portfolio     registered weights, held until next start
// ---------------------------------------------------------------------------
module eigenportfolio_n #(
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int N_STOCKS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(N_STOCKS)-1:0]   rank,
    input  logic signed [WIDTH-1:0]       eigenvectors [N_STOCKS][N_STOCKS],
    input  logic signed [WIDTH-1:0]       eigenvalues  [N_STOCKS],
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          sat,
    output logic [$clog2(N_STOCKS)-1:0]   sel_idx,
    output logic signed [WIDTH-1:0]       portfolio [N_STOCKS]
);

    localparam int RANK_W = $clog2(N_STOCKS);
    // Sum of N WIDTH-bit words needs no truncation at this width.
    localparam int SW     = WIDTH + RANK_W + 1;
    // Dividend is |v| << FRAC.
    localparam int DW     = WIDTH + FRAC;
    localparam int BW     = $clog2(DW + 1);

    localparam logic [RANK_W:0]   N_EXT    = (RANK_W + 1)'(N_STOCKS);
    localparam logic [RANK_W-1:0] LAST_IDX = RANK_W'(N_STOCKS - 1);
    localparam logic [BW-1:0]     BIT_LAST = BW'(DW);
    localparam logic [DW-1:0]     POS_LIM  = DW'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic [DW-1:0]     NEG_LIM  = DW'(longint'(1) << (WIDTH - 1));

    typedef enum logic [2:0] {
        IDLE,
        RANK,
        SUM,
        DIV,
        DONE_ST
    } state_t;

    state_t state_reg, state_next;

    // Captured request
    logic signed [WIDTH-1:0] evec_reg [N_STOCKS][N_STOCKS];
    logic signed [WIDTH-1:0] eval_reg [N_STOCKS];
    logic [RANK_W-1:0]       rank_reg;

    // Sequencing
    logic [RANK_W-1:0]       step_reg;   // candidate / element index
    logic [BW-1:0]           bit_reg;    // 0 = setup, 1..DW = iterations
    logic [RANK_W-1:0]       sel_reg;

    // Sum and divider datapath
    logic signed [SW-1:0]    acc_reg;
    logic [SW-1:0]           dmag_reg;   // |divisor|
    logic                    sum_neg_reg;
    logic                    neg_reg;    // sign of the current quotient
    logic [DW-1:0]           dvd_reg;
    logic [DW-1:0]           quo_reg;
    logic [SW-1:0]           rem_reg;

    // Status / results
    logic                    busy_reg, done_reg, err_reg, sat_reg;
    logic signed [WIDTH-1:0] port_reg [N_STOCKS];

    // ------------------------------------------------------------------
    // Rank of candidate step_reg: how many eigenvalues beat it. A value
    // beats the candidate if it is larger, or if it is equal and sits at
    // a lower index. That gives every column a distinct rank.
    // ------------------------------------------------------------------
    logic [N_STOCKS-1:0] beats;
    logic [RANK_W:0]     rank_count;

    genvar gi;
    generate
        for (gi = 0; gi < N_STOCKS; gi++) begin : g_beats
            assign beats[gi] = (eval_reg[gi] > eval_reg[step_reg]) ||
                               ((eval_reg[gi] == eval_reg[step_reg]) &&
                                (RANK_W'(gi) < step_reg));
        end
    endgenerate

    always_comb begin
        rank_count = '0;
        for (int i = 0; i < N_STOCKS; i++) begin
            rank_count = rank_count + (RANK_W + 1)'(beats[i]);
        end
    end

    logic rank_bad, step_last, bit_last;
    assign rank_bad  = ({1'b0, rank_reg} >= N_EXT);
    assign step_last = (step_reg == LAST_IDX);
    assign bit_last  = (bit_reg == BIT_LAST);

    // Element of the selected column addressed by step_reg
    logic signed [WIDTH-1:0] cur_elem;
    logic [WIDTH-1:0]        cur_mag;
    assign cur_elem = evec_reg[step_reg][sel_reg];
    assign cur_mag  = cur_elem[WIDTH-1] ? WIDTH'(-cur_elem) : WIDTH'(cur_elem);

    logic signed [SW-1:0] sum_term, acc_sum;
    logic [SW-1:0]        acc_mag;
`ifdef ABS_NORM_EN
    assign sum_term = {{(SW - WIDTH){1'b0}}, cur_mag};
`else
    assign sum_term = {{(SW - WIDTH){cur_elem[WIDTH-1]}}, cur_elem};
`endif
    assign acc_sum = acc_reg + sum_term;
    assign acc_mag = acc_sum[SW-1] ? SW'(-acc_sum) : SW'(acc_sum);

    // One restoring-division step on magnitudes. The remainder stays below
    // the divisor, so the shifted trial value fits in SW+1 bits.
    logic [SW:0]   trial;
    logic          fits;
    logic [SW-1:0] rem_step;
    logic [DW-1:0] quo_step;
    assign trial    = {rem_reg, dvd_reg[DW-1]};
    assign fits     = (trial >= {1'b0, dmag_reg});
    assign rem_step = SW'(fits ? (trial - {1'b0, dmag_reg}) : trial);
    assign quo_step = {quo_reg[DW-2:0], fits};

    // Apply the quotient sign after division (truncation toward zero),
    // then clamp to the signed WIDTH range.
    logic signed [WIDTH-1:0] res;
    logic                    clamp;
    always_comb begin
        res   = '0;
        clamp = 1'b0;
        if (!neg_reg) begin
            if (quo_step > POS_LIM) begin
                clamp = 1'b1;
                res   = {1'b0, {(WIDTH - 1){1'b1}}};
            end else begin
                res = quo_step[WIDTH-1:0];
            end
        end else begin
            if (quo_step > NEG_LIM) begin
                clamp = 1'b1;
                res   = {1'b1, {(WIDTH - 1){1'b0}}};
            end else begin
                res = -quo_step[WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RANK;
            end
            RANK: begin
                if (rank_bad)       state_next = DONE_ST;
                else if (step_last) state_next = SUM;
            end
            SUM: begin
                if (step_last) state_next = (acc_sum == '0) ? DONE_ST : DIV;
            end
            DIV: begin
                if (bit_last && step_last) state_next = DONE_ST;
            end
            DONE_ST: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_STOCKS; r++) begin
                for (int c = 0; c < N_STOCKS; c++) begin
                    evec_reg[r][c] <= '0;
                end
                eval_reg[r] <= '0;
                port_reg[r] <= '0;
            end
            rank_reg    <= '0;
            step_reg    <= '0;
            bit_reg     <= '0;
            sel_reg     <= '0;
            acc_reg     <= '0;
            dmag_reg    <= '0;
            sum_neg_reg <= 1'b0;
            neg_reg     <= 1'b0;
            dvd_reg     <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            sat_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < N_STOCKS; r++) begin
                            for (int c = 0; c < N_STOCKS; c++) begin
                                evec_reg[r][c] <= eigenvectors[r][c];
                            end
                            eval_reg[r] <= eigenvalues[r];
                        end
                        rank_reg <= rank;
                        step_reg <= '0;
                        busy_reg <= 1'b1;
                        err_reg  <= 1'b0;
                        sat_reg  <= 1'b0;
                    end
                end

                RANK: begin
                    if (rank_bad) begin
                        err_reg <= 1'b1;
                        for (int i = 0; i < N_STOCKS; i++) port_reg[i] <= '0;
                    end else begin
                        if (rank_count == {1'b0, rank_reg}) sel_reg <= step_reg;
                        if (step_last) begin
                            step_reg <= '0;
                            acc_reg  <= '0;
                        end else begin
                            step_reg <= step_reg + 1'b1;
                        end
                    end
                end

                SUM: begin
                    acc_reg <= acc_sum;
                    if (step_last) begin
                        step_reg    <= '0;
                        bit_reg     <= '0;
                        dmag_reg    <= acc_mag;
                        sum_neg_reg <= acc_sum[SW-1];
                        if (acc_sum == '0) begin
                            err_reg <= 1'b1;
                            for (int i = 0; i < N_STOCKS; i++) port_reg[i] <= '0;
                        end
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end

                DIV: begin
                    if (bit_reg == '0) begin
                        // Setup cycle: load the magnitude of the element.
                        dvd_reg <= DW'(cur_mag) << FRAC;
                        rem_reg <= '0;
                        quo_reg <= '0;
                        neg_reg <= cur_elem[WIDTH-1] ^ sum_neg_reg;
                        bit_reg <= BW'(1);
                    end else begin
                        rem_reg <= rem_step;
                        quo_reg <= quo_step;
                        dvd_reg <= dvd_reg << 1;
                        if (bit_last) begin
                            port_reg[step_reg] <= res;
                            sat_reg            <= sat_reg | clamp;
                            bit_reg            <= '0;
                            step_reg           <= step_last ? '0 : step_reg + 1'b1;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end
                end

                DONE_ST: begin
                    done_reg <= 1'b1;
                    busy_reg <= 1'b0;
                end

                default: ;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign err     = err_reg;
    assign sat     = sat_reg;
    assign sel_idx = sel_reg;

    generate
        for (gi = 0; gi < N_STOCKS; gi++) begin : g_port
            assign portfolio[gi] = port_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_eigenportfolio_n.sv
// ---------------------------------------------------------------------------
// Self-checking bench for eigenportfolio_n, built with N_STOCKS = 3 so that
// rank = 3 exercises the out-of-range path. Expected results come from a
// sort-and-divide reference model.
// ---------------------------------------------------------------------------
module tb_eigenportfolio_n;

    localparam int N   = 3;
    localparam int W   = 16;
    localparam int F   = 8;
    localparam int RW  = $clog2(N);
    localparam int LAT = 1 + 2 * N + N * (W + F + 1);
    localparam int WMAX = (1 << (W - 1)) - 1;
    localparam int WMIN = -(1 << (W - 1));

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [RW-1:0]       rank = '0;
    logic signed [W-1:0] ev_mat  [N][N];
    logic signed [W-1:0] ev_vals [N];
    logic                busy, done, err, sat;
    logic [RW-1:0]       sel_idx;
    logic signed [W-1:0] portfolio [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eigenportfolio_n #(
        .WIDTH   (W),
        .FRAC    (F),
        .N_STOCKS(N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rank        (rank),
        .eigenvectors(ev_mat),
        .eigenvalues (ev_vals),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .sat         (sat),
        .sel_idx     (sel_idx),
        .portfolio   (portfolio)
    );

    // Directed cases: eigenvalues, column holding the vector, rank, vector
    localparam int NCASE = 7;
    int d_ev  [NCASE][N] = '{'{5, 9, 2}, '{3, 3, 1}, '{3, 3, 1}, '{3, 3, 1},
                             '{1, 2, 3}, '{4, 1, 0}, '{4, 1, 0}};
    int d_col [NCASE]    = '{0, 0, 1, 2, 0, 0, 0};
    int d_rk  [NCASE]    = '{1, 0, 1, 2, 3, 0, 0};
    int d_v   [NCASE][N] = '{'{256, 256, 512}, '{256, 256, 512}, '{256, 256, 512},
                             '{100, -50, 70}, '{1, 2, 3}, '{256, -256, 0},
                             '{300, -299, 0}};

    function automatic logic signed [W-1:0] rnd(input int lo, input int hi);
        int x;
        x = lo + int'($urandom_range(hi - lo, 0));
        return W'(x);
    endfunction

    // Reference model. Rank the columns by sorting the eigenvalues in
    // descending order, with the lower index first on equal values. Then
    // divide each element by the column sum.
    function automatic void model(input int rk, output int sel, output bit e,
                                  output bit s, output int w [N]);
        int     order [N];
        bit     used  [N];
        int     best;
        longint sum, q, v;
        sel = 0; e = 1'b0; s = 1'b0;
        for (int i = 0; i < N; i++) begin
            w[i] = 0;
            used[i] = 1'b0;
        end
        for (int p = 0; p < N; p++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i] && (best < 0 || ev_vals[i] > ev_vals[best])) best = i;
            end
            order[p] = best;
            used[best] = 1'b1;
        end
        if (rk >= N) begin
            e = 1'b1;
            return;
        end
        sel = order[rk];
        sum = 0;
        for (int i = 0; i < N; i++) begin
            v = longint'(ev_mat[i][sel]);
`ifdef ABS_NORM_EN
            sum += (v < 0) ? -v : v;
`else
            sum += v;
`endif
        end
        if (sum == 0) begin
            e = 1'b1;
            return;
        end
        for (int i = 0; i < N; i++) begin
            q = (longint'(ev_mat[i][sel]) * (longint'(1) << F)) / sum;
            if (q > WMAX) begin q = WMAX; s = 1'b1; end
            if (q < WMIN) begin q = WMIN; s = 1'b1; end
            w[i] = int'(q);
        end
    endfunction

    task automatic scramble();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) ev_mat[r][c] = rnd(-30000, 30000);
            ev_vals[r] = rnd(-30000, 30000);
        end
        rank = RW'($urandom_range(3, 0));
    endtask

    task automatic load_case(input int k);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) ev_mat[r][c] = rnd(-400, 400);
        for (int i = 0; i < N; i++) begin
            ev_vals[i] = W'(d_ev[k][i]);
            ev_mat[i][d_col[k]] = W'(d_v[k][i]);
        end
    endtask

    // Issue one request and wait for done. Inputs are scrambled after
    // capture. With poke set, a second start is raised while busy.
    task automatic run_op(input int rk, input bit poke, output int lat,
                          output logic [RW-1:0] o_sel, output logic o_err,
                          output logic o_sat, output logic signed [W-1:0] o_pf [N]);
        @(negedge clk);
        rank  = RW'(rk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        lat = -1;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(posedge clk); #1;
            if (poke && c == 20) begin scramble(); start = 1'b1; end
            if (poke && c == 21) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        o_sel = sel_idx;
        o_err = err;
        o_sat = sat;
        o_pf  = portfolio;
        $display("txn rank=%0d sel=%0d err=%0d sat=%0d lat=%0d pf=%0d,%0d,%0d",
                 rk, o_sel, o_err, o_sat, lat, o_pf[0], o_pf[1], o_pf[2]);
    endtask

    task automatic test_reset();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) ev_mat[r][c] = '0;
            ev_vals[r] = '0;
        end
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
        checks++; if (sel_idx !== '0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel_idx); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (portfolio[i] !== '0) begin errors++; $display("FAIL reset_pf[%0d] got %0d want 0", i, portfolio[i]); end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int lat, e_sel; bit e_err, e_sat; int e_w [N];
        logic [RW-1:0] o_sel; logic o_err, o_sat; logic signed [W-1:0] o_pf [N];
        for (int k = 0; k < NCASE; k++) begin
            load_case(k);
            model(d_rk[k], e_sel, e_err, e_sat, e_w);
            run_op(d_rk[k], 1'b0, lat, o_sel, o_err, o_sat, o_pf);
            checks++;
            if (e_err ? !(lat > 0 && lat < LAT) : (lat != LAT)) begin
                errors++; $display("FAIL dir%0d latency got %0d want %0d", k, lat, e_err ? -2 : LAT);
            end
            checks++; if (o_err !== e_err) begin errors++; $display("FAIL dir%0d err got %b want %b", k, o_err, e_err); end
            checks++; if (o_sat !== e_sat) begin errors++; $display("FAIL dir%0d sat got %b want %b", k, o_sat, e_sat); end
            if (d_rk[k] < N) begin
                checks++; if (o_sel !== RW'(e_sel)) begin errors++; $display("FAIL dir%0d sel got %0d want %0d", k, o_sel, e_sel); end
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_pf[i] !== W'(e_w[i])) begin errors++; $display("FAIL dir%0d pf[%0d] got %0d want %0d", k, i, o_pf[i], e_w[i]); end
            end
        end
    endtask

    task automatic test_random();
        int lat, rk, e_sel; bit e_err, e_sat; int e_w [N];
        logic [RW-1:0] o_sel; logic o_err, o_sat; logic signed [W-1:0] o_pf [N];
        for (int k = 0; k < 25; k++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) ev_mat[r][c] = (k % 4 == 3) ? rnd(-3, 3) : rnd(-600, 600);
                ev_vals[r] = rnd(-3, 3);
            end
            rk = int'($urandom_range(3, 0));
            model(rk, e_sel, e_err, e_sat, e_w);
            run_op(rk, 1'b0, lat, o_sel, o_err, o_sat, o_pf);
            checks++;
            if (e_err ? !(lat > 0 && lat < LAT) : (lat != LAT)) begin
                errors++; $display("FAIL rnd%0d latency got %0d want %0d", k, lat, e_err ? -2 : LAT);
            end
            checks++; if (o_err !== e_err) begin errors++; $display("FAIL rnd%0d err got %b want %b", k, o_err, e_err); end
            checks++; if (o_sat !== e_sat) begin errors++; $display("FAIL rnd%0d sat got %b want %b", k, o_sat, e_sat); end
            if (rk < N) begin
                checks++; if (o_sel !== RW'(e_sel)) begin errors++; $display("FAIL rnd%0d sel got %0d want %0d", k, o_sel, e_sel); end
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_pf[i] !== W'(e_w[i])) begin errors++; $display("FAIL rnd%0d pf[%0d] got %0d want %0d", k, i, o_pf[i], e_w[i]); end
            end
        end
    endtask

    task automatic test_handshake();
        int lat, e_sel, extra; bit e_err, e_sat; int e_w [N];
        logic [RW-1:0] o_sel; logic o_err, o_sat; logic signed [W-1:0] o_pf [N];
        load_case(0);
        model(d_rk[0], e_sel, e_err, e_sat, e_w);
        run_op(d_rk[0], 1'b1, lat, o_sel, o_err, o_sat, o_pf);
        checks++; if (lat != LAT) begin errors++; $display("FAIL hs latency got %0d want %0d", lat, LAT); end
        checks++; if (o_sel !== RW'(e_sel)) begin errors++; $display("FAIL hs sel got %0d want %0d", o_sel, e_sel); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_pf[i] !== W'(e_w[i])) begin errors++; $display("FAIL hs pf[%0d] got %0d want %0d", i, o_pf[i], e_w[i]); end
        end
        extra = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL hs extra_done got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, e_sel; bit e_err, e_sat; int e_w [N];
        logic [RW-1:0] o_sel; logic o_err, o_sat; logic signed [W-1:0] o_pf [N];
        for (int k = 0; k < 2; k++) begin
            load_case(k == 0 ? 3 : 6);
            model(k == 0 ? d_rk[3] : d_rk[6], e_sel, e_err, e_sat, e_w);
            run_op(k == 0 ? d_rk[3] : d_rk[6], 1'b0, lat, o_sel, o_err, o_sat, o_pf);
            checks++; if (lat != LAT) begin errors++; $display("FAIL b2b%0d latency got %0d want %0d", k, lat, LAT); end
            checks++; if (o_sat !== e_sat) begin errors++; $display("FAIL b2b%0d sat got %b want %b", k, o_sat, e_sat); end
            checks++; if (o_sel !== RW'(e_sel)) begin errors++; $display("FAIL b2b%0d sel got %0d want %0d", k, o_sel, e_sel); end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (o_pf[i] !== W'(e_w[i])) begin errors++; $display("FAIL b2b%0d pf[%0d] got %0d want %0d", k, i, o_pf[i], e_w[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, e_sel, seen; bit e_err, e_sat; int e_w [N];
        logic [RW-1:0] o_sel; logic o_err, o_sat; logic signed [W-1:0] o_pf [N];
        load_case(6);
        @(negedge clk);
        rank  = RW'(d_rk[6]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid pre_busy got %b want 1", busy); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL rstmid pre_sat got %b want 1", sat); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid err got %b want 0", err); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL rstmid sat got %b want 0", sat); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (portfolio[i] !== '0) begin errors++; $display("FAIL rstmid pf[%0d] got %0d want 0", i, portfolio[i]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < LAT; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid stale_activity got %0d want 0", seen); end
        load_case(0);
        model(d_rk[0], e_sel, e_err, e_sat, e_w);
        run_op(d_rk[0], 1'b0, lat, o_sel, o_err, o_sat, o_pf);
        checks++; if (lat != LAT) begin errors++; $display("FAIL rstmid latency got %0d want %0d", lat, LAT); end
        checks++; if (o_err !== e_err) begin errors++; $display("FAIL rstmid post_err got %b want %b", o_err, e_err); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (o_pf[i] !== W'(e_w[i])) begin errors++; $display("FAIL rstmid post_pf[%0d] got %0d want %0d", i, o_pf[i], e_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
